// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and TX-FIFO-side signals of the UART
// transmit arbiter. The slave modport is the arbiter; the master modport is
// the environment that owns the requesters and the TX FIFO.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 tx_full;
    logic [7:0]           w_data;
    logic                 wr_uart;

    modport slave (
        input  req, req_data, req_last, tx_full,
        output ack, grant, busy, w_data, wr_uart
    );

    modport master (
        output req, req_data, req_last, tx_full,
        input  ack, grant, busy, w_data, wr_uart
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO write port between NUM_REQ byte
// streams. Ownership is per packet (until a last byte or MAX_BURST bytes),
// followed by one GAP cycle before the next arbitration in IDLE.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for lowest-index-wins
// arbitration; default is round-robin starting after the previous winner.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      gidx_q;     // index of the current owner
    logic [CW-1:0]      cnt_q;      // bytes accepted in this grant
    logic               busy_q;
    logic [IW-1:0]      win_d;      // arbitration winner for this cycle
    logic               any_req_d;
    logic               accept_d;
    logic               release_d;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest index with a pending request wins.
    always_comb begin
        win_d = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win_d = IW'(i);
        end
    end
`else
    logic [IW-1:0] last_q;          // previous winner, round-robin pointer
    logic [IW:0]   cand_d;

    // Round-robin: scan last+1, last+2, ... wrapping; nearest candidate wins,
    // so the loop runs far-to-near and the final hit is kept.
    always_comb begin
        win_d  = '0;
        cand_d = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_d = {1'b0, last_q} + (IW+1)'(k);
            if (cand_d >= (IW+1)'(NUM_REQ)) cand_d = cand_d - (IW+1)'(NUM_REQ);
            if (bus.req[cand_d[IW-1:0]]) win_d = cand_d[IW-1:0];
        end
    end
`endif

    // Write-port datapath: owner's byte goes straight to the FIFO; accept
    // happens only while the owner offers data and the FIFO has room.
    always_comb begin
        any_req_d   = |bus.req;
        accept_d    = busy_q & bus.req[gidx_q] & ~bus.tx_full & ~reset;
        release_d   = accept_d &
                      (bus.req_last[gidx_q] | (cnt_q == CW'(MAX_BURST - 1)));
        bus.ack     = '0;
        bus.wr_uart = accept_d;
        bus.w_data  = '0;
        if (busy_q && !reset) bus.w_data = bus.req_data[{gidx_q, 3'b000} +: 8];
        if (accept_d) bus.ack[gidx_q] = 1'b1;
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

    // Ownership FSM: IDLE arbitrates, BUSY counts accepted bytes until
    // release, GAP forces one dead cycle between owners.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q  <= IW'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q <= BUSY;
                        grant_q <= NUM_REQ'(1) << win_d;
                        gidx_q  <= win_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        last_q  <= win_d;
`endif
                    end
                end
                BUSY: begin
                    if (release_d) begin
                        state_q <= GAP;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (accept_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with per-requester byte sources and a
// per-requester scoreboard of expected bytes checked on every FIFO write.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0]    src   [NR][$];   // {last, data} still to be offered
    logic [7:0]    exp_q [NR][$];   // bytes expected at the FIFO, per source
    logic [NR-1:0] hold;            // forces a requester's req low
    int            wr_owner_q[$];   // owner of each observed write
    logic [NR-1:0] start_g[$];      // grant value at each packet start
    int            start_c[$];      // cycle of each packet start
    logic [NR-1:0] s_grant, s_ack, prev_grant;
    logic          s_busy, s_wr;
    logic [7:0]    s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += src[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src[i].size() > 0 && !hold[i]) begin
                bus.req[i]           = 1'b1;
                bus.req_data[i*8 +: 8] = src[i][0][7:0];
                bus.req_last[i]      = src[i][0][8];
            end else begin
                bus.req[i]           = 1'b0;
                bus.req_data[i*8 +: 8] = 8'h00;
                bus.req_last[i]      = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            logic       lst;
            b   = base + 8'(k);
            lst = (k == n - 1);
            src[r].push_back({lst, b});
            exp_q[r].push_back(b);
        end
    endtask

    // One clock: sample at negedge, score writes, then advance sources.
    task automatic tick();
        logic [NR-1:0] acked;
        int            owner;
        @(negedge clk);
        s_grant = bus.grant;
        s_busy  = bus.busy;
        s_wr    = bus.wr_uart;
        s_wdata = bus.w_data;
        s_ack   = bus.ack;
        acked   = '0;
        if (s_wr) begin
            owner = -1;
            for (int i = 0; i < NR; i++) if (s_ack[i]) owner = i;
            chk("ack_matches_grant", 32'(s_ack), 32'(s_grant));
            chk("write_has_pending", 32'(owner >= 0 && exp_q[owner >= 0 ? owner : 0].size() > 0), 1);
            if (owner >= 0 && exp_q[owner].size() > 0) begin
                chk("w_data", 32'(s_wdata), 32'(exp_q[owner].pop_front()));
                wr_owner_q.push_back(owner);
                acked = s_ack;
            end
        end else begin
            chk("ack_without_write", 32'(s_ack), 0);
        end
        if (s_grant != '0 && prev_grant == '0) begin
            start_g.push_back(s_grant);
            start_c.push_back(cyc);
        end
        prev_grant = s_grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acked[i] && src[i].size() > 0) void'(src[i].pop_front());
        cyc++;
        drive();
    endtask

    task automatic run_until_empty(input string tag, input int maxc);
        int n = 0;
        while (pending() != 0 && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(pending()), 0);
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src[i].delete();
            exp_q[i].delete();
        end
        hold = '0;
        bus.tx_full = 1'b0;
        drive();
        @(negedge clk);
        reset = 1'b0;
        prev_grant = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        logic [NR-1:0] rr_exp [6];
        int nstarts;

        hold         = '0;
        prev_grant   = '0;
        bus.tx_full  = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 32'hDEADBEEF;
        bus.req_last = 4'b1111;

        // Reset state with requests present: nothing may be written.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_grant", 32'(bus.grant), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_wr", 32'(bus.wr_uart), 0);
        chk("reset_ack", 32'(bus.ack), 0);
        chk("reset_wdata", 32'(bus.w_data), 0);
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single packet from requester 1.
        load(1, 3, 8'hA1);
        drive();
        tick(); chk("t1_idle_grant", 32'(s_grant), 0);
        tick(); chk("t1_grant", 32'(s_grant), 32'h2);
                chk("t1_busy", 32'(s_busy), 1);
                chk("t1_wr1", 32'(s_wr), 1);
        tick(); chk("t1_wr2", 32'(s_wr), 1);
        tick(); chk("t1_wr3", 32'(s_wr), 1);
        tick(); chk("t1_gap_grant", 32'(s_grant), 0);
                chk("t1_gap_wr", 32'(s_wr), 0);
                chk("t1_gap_busy", 32'(s_busy), 0);
        tick();
        chk("t1_drained", 32'(pending()), 0);

        // All four requesting, 1-byte packets.
        apply_reset();
        start_g.delete();
        start_c.delete();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        load(0, 1, 8'h20); load(0, 1, 8'h21); load(0, 1, 8'h22);
        load(1, 1, 8'h30); load(2, 1, 8'h40); load(3, 1, 8'h50);
        rr_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        nstarts = 6;
`else
        load(0, 1, 8'h20); load(1, 1, 8'h30); load(2, 1, 8'h40);
        load(3, 1, 8'h50); load(0, 1, 8'h21);
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        nstarts = 5;
`endif
        drive();
        run_until_empty("rr", 60);
        chk("rr_start_count", 32'(start_g.size()), 32'(nstarts));
        for (int k = 0; k < nstarts && k < start_g.size(); k++) begin
            chk("rr_order", 32'(start_g[k]), 32'(rr_exp[k]));
            if (k > 0) chk("rr_spacing", 32'(start_c[k] - start_c[k-1]), 3);
        end

        // Back-pressure on cycles 2-4 of a 4-byte packet.
        base = wr_owner_q.size();
        load(0, 4, 8'h10);
        drive();
        tick();
        tick(); chk("bp_first_wr", 32'(s_wr), 1);
        bus.tx_full = 1'b1;
        repeat (3) begin
            tick();
            chk("bp_full_wr", 32'(s_wr), 0);
            chk("bp_full_grant", 32'(s_grant), 32'h1);
        end
        bus.tx_full = 1'b0;
        run_until_empty("bp", 20);
        chk("bp_write_count", 32'(wr_owner_q.size() - base), 4);

        // Burst limit: 20-byte packet on 2 with a 1-byte packet pending on 3.
        base = wr_owner_q.size();
        load(2, 20, 8'h80);
        load(3, 1, 8'hC0);
        drive();
        run_until_empty("burst", 100);
        chk("burst_write_count", 32'(wr_owner_q.size() - base), 21);
        if (wr_owner_q.size() - base == 21) begin
            chk("burst_byte16_owner", 32'(wr_owner_q[base+15]), 2);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            chk("burst_after16_owner", 32'(wr_owner_q[base+16]), 2);
            chk("burst_final_owner", 32'(wr_owner_q[base+20]), 3);
`else
            chk("burst_after16_owner", 32'(wr_owner_q[base+16]), 3);
            chk("burst_regrant_owner", 32'(wr_owner_q[base+17]), 2);
            chk("burst_final_owner", 32'(wr_owner_q[base+20]), 2);
`endif
        end

        // Reset after 2 of 5 bytes.
        base = wr_owner_q.size();
        load(1, 5, 8'h50);
        drive();
        n = 0;
        while (wr_owner_q.size() - base < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_two_written", 32'(wr_owner_q.size() - base), 2);
        reset = 1'b1;
        #1;
        chk("rst_async_grant", 32'(bus.grant), 0);
        chk("rst_async_busy", 32'(bus.busy), 0);
        chk("rst_async_wr", 32'(bus.wr_uart), 0);
        src[1].delete();
        exp_q[1].delete();
        drive();
        @(negedge clk);
        reset = 1'b0;
        prev_grant = '0;
        @(posedge clk);
        #1;
        start_g.delete();
        start_c.delete();
        load(1, 1, 8'h90);
        load(2, 1, 8'hA0);
        drive();
        run_until_empty("rst", 20);
        chk("rst_start_count", 32'(start_g.size()), 2);
        if (start_g.size() >= 2) begin
            chk("rst_first_owner", 32'(start_g[0]), 32'h2);
            chk("rst_second_owner", 32'(start_g[1]), 32'h4);
        end

        // Owner drops req for 3 cycles while requester 1 waits.
        apply_reset();
        base = wr_owner_q.size();
        load(0, 6, 8'h60);
        load(1, 2, 8'h70);
        drive();
        n = 0;
        while (wr_owner_q.size() - base < 2 && n < 20) begin
            tick();
            n++;
        end
        hold[0] = 1'b1;
        drive();
        repeat (3) begin
            tick();
            chk("stall_grant_held", 32'(s_grant), 32'h1);
            chk("stall_no_write", 32'(s_wr), 0);
        end
        hold[0] = 1'b0;
        drive();
        run_until_empty("stall", 40);
        chk("stall_write_count", 32'(wr_owner_q.size() - base), 8);
        if (wr_owner_q.size() - base == 8) begin
            for (int k = 0; k < 8; k++)
                chk("stall_owner_seq", 32'(wr_owner_q[base+k]), (k < 6) ? 0 : 1);
        end

        chk("scoreboard_empty", 32'(pending()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port (`w_data`/`wr_uart`, back-pressured by `tx_full`) between `NUM_REQ` independent byte-stream requesters. Grants are packet-based: once a requester wins, it owns the FIFO write port until it marks a byte as last or hits the burst limit. Arbitration is round-robin by default. The block sits between the requesting engines and the UART top-level transmit FIFO.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `MAX_BURST`, 16, maximum bytes per grant before forced release; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester valid; held high while the byte on `req_data` is offered.
- `req_data`  in  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  qualifies the offered byte as the final byte of the packet.
- `ack`  out  NUM_REQ  one-hot; byte accepted this cycle (combinational).
- `grant`  out  NUM_REQ  one-hot registered owner; all-zero when no owner.
- `busy`  out  1  high in BUSY state.
- `tx_full`  in  1  UART TX FIFO full.
- `w_data`  out  8  byte to TX FIFO (combinational mux of granted `req_data`).
- `wr_uart`  out  1  TX FIFO write strobe (combinational).

## Operation
- States: IDLE, BUSY, GAP. Reset → IDLE, `grant`=0, `busy`=0, burst count=0, RR pointer `last`=NUM_REQ-1. `ack`/`wr_uart`=0 and `w_data`=0 while in reset.
- IDLE: if any `req` is high, select the first requester with `req` high, scanning `last+1`, `last+2`, … modulo NUM_REQ. Register it into `grant`, clear the burst count, set `last` to the winner, and go to BUSY. With no `req`, stay in IDLE.
- BUSY, owner g: `wr_uart` = `ack[g]` = `req[g] & ~tx_full`; `w_data` = byte g. Each accept increments the burst count.
- Release condition: an accepted byte with `req_last[g]`=1, or an accept with burst count = MAX_BURST-1. On release, go to GAP.
- A forced release does not end the packet from the requester's view. It keeps `req` high and rearbitrates for the remainder.
- `req[g]` low in BUSY: grant is held and nothing is written. Requesters must not abandon a packet.
- `req_last` is ignored on cycles without accept.
- GAP: `grant`=0, no writes; go to IDLE next cycle. The GAP cycle guarantees a one-cycle idle between owners.
- Non-granted requesters never see `ack`. Their `req_data` is don't-care.
- Burst counter width is clog2(MAX_BURST+1) bits; it never wraps because release occurs at MAX_BURST.

## Timing
- `req` rises at cycle t in IDLE → `grant`/`busy` high at t+1 → first `wr_uart` at t+1 if `tx_full`=0.
- Throughput: one byte per cycle while `req[g]` is high and `tx_full` is low.
- `tx_full` asserts: `wr_uart` drops the same cycle. No byte is lost and none is duplicated.
- Last byte accepted at t → GAP at t+1 → IDLE at t+2 → next owner granted at t+3. Minimum dead time between packets is 2 cycles.
- Requests arriving while BUSY or in GAP wait; they are evaluated in IDLE.
- `reset` asserted mid-packet: immediate return to IDLE with outputs zeroed. The partial packet is truncated; requesters are responsible for recovery.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`
  - Defined: IDLE selects the lowest-index requester with `req` high; `last` is unused.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- **Single packet:** with `tx_full`=0, requester 1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3).
  - `grant`=4'b0010 one cycle after `req`.
  - `wr_uart` high for 3 consecutive cycles with `w_data` A1, A2, A3.
  - Then GAP and `grant`=0.
- **Round-robin:** `req`=4'b1111 held, each packet 1 byte with last.
  - Grant order is 0, 1, 2, 3, 0.
  - Packet starts are 3 cycles apart.
  - With `UART_TX_ARB_FIXED_PRIO_EN`, the grant order is 0, 0, 0.
- **Back-pressure:** requester 0 sends 4 bytes; `tx_full` is high for cycles 2–4 of the packet.
  - `wr_uart` stays low during those cycles.
  - All 4 bytes are written exactly once, in order.
- **Burst limit:** MAX_BURST=16, requester 2 sends a 20-byte packet while requester 3 is pending.
  - Requester 2 releases after byte 16.
  - Requester 3's 1-byte packet is granted next.
  - Requester 2 is then regranted for bytes 17–20.
- **Reset mid-packet:** `reset` pulses after 2 of 5 bytes.
  - `grant`, `busy`, `wr_uart` go to 0 asynchronously.
  - After release, an IDLE arbitration restarts from `last`=NUM_REQ-1.
- **Stall:** `req[g]` drops for 3 cycles mid-packet while another requester is active.
  - Grant is held with no writes.
  - The packet resumes when `req[g]` returns.
